// File: rtl/l3_trace_dispatch_if.sv
`default_nettype none
// ============================================================================
// Module   : l3_trace_dispatch_if
// Brief    : Trace-in / command-out handshake bundle for l3_trace_dispatch.
// Revision : 1.0 - initial release
// ============================================================================
interface l3_trace_dispatch_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [ADDR_W-1:0] in_addr;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        out_op;
    logic [ADDR_W-1:0] out_addr;
    logic [CNT_W-1:0]  out_seq;

    // Trace source and cache consumer side
    modport master (
        output in_valid, in_op, in_addr, out_ready,
        input  in_ready, out_valid, out_op, out_addr, out_seq
    );

    // Dispatcher side
    modport slave (
        input  in_valid, in_op, in_addr, out_ready,
        output in_ready, out_valid, out_op, out_addr, out_seq
    );
endinterface
`default_nettype wire

// File: rtl/l3_trace_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : l3_trace_dispatch
// Brief    : Trace FIFO that tags records with a sequence number, dispatches
//            cache ops 0-6 and turns ops 8/9 into in-order one-cycle pulses.
// Revision : 1.0 - initial release
// ============================================================================
module l3_trace_dispatch #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 32
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    l3_trace_dispatch_if.slave            bus,
    output logic                          clear_pulse_o,
    output logic                          print_pulse_o,
    output logic [$clog2(DEPTH):0]        fifo_level_o,
    output logic [CNT_W-1:0]              cpu_count_o,
    output logic [CNT_W-1:0]              snoop_count_o,
    output logic [CNT_W-1:0]              illegal_count_o
);
    localparam int               PTR_W     = $clog2(DEPTH);
    localparam int               LVL_W     = PTR_W + 1;
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);
    localparam logic [3:0]       OP_CLEAR  = 4'd8;
    localparam logic [3:0]       OP_PRINT  = 4'd9;
    localparam logic [3:0]       OP_MAXCMD = 4'd6;
    localparam logic [3:0]       OP_MAXCPU = 4'd2;

    logic [3:0]        op_mem   [DEPTH];
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [CNT_W-1:0]  seq_mem  [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [CNT_W-1:0]  seq_q;
    logic [CNT_W-1:0]  cpu_cnt_q, snoop_cnt_q, ill_cnt_q;
    logic              clear_q, print_q;

    logic              w_accept, w_legal, w_push;
    logic              w_nonempty, w_head_cmd, w_head_ctl;
    logic              w_pop_cmd, w_pop;
    logic [3:0]        w_head_op;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    assign bus.in_ready = (level_q != LVL_FULL);
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_legal      = (bus.in_op <= OP_MAXCMD) || (bus.in_op == OP_CLEAR) ||
                          (bus.in_op == OP_PRINT);
    assign w_push       = w_accept && w_legal;

    // Only legal ops are stored, so a non-empty head is either a command or a control op
    assign w_head_op    = op_mem[rd_ptr_q];
    assign w_nonempty   = (level_q != '0);
    assign w_head_cmd   = w_nonempty && (w_head_op <= OP_MAXCMD);
    assign w_head_ctl   = w_nonempty && ((w_head_op == OP_CLEAR) || (w_head_op == OP_PRINT));
    assign w_pop_cmd    = w_head_cmd && bus.out_ready;
    assign w_pop        = w_pop_cmd || w_head_ctl;

    assign bus.out_valid = w_head_cmd;
    assign bus.out_op    = w_head_op;
    assign bus.out_addr  = addr_mem[rd_ptr_q];
    assign bus.out_seq   = seq_mem[rd_ptr_q];

    always_comb begin
        level_d = level_q;
        case ({w_push, w_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            op_mem[wr_ptr_q]   <= bus.in_op;
            addr_mem[wr_ptr_q] <= bus.in_addr;
            seq_mem[wr_ptr_q]  <= seq_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            seq_q       <= '0;
            cpu_cnt_q   <= '0;
            snoop_cnt_q <= '0;
            ill_cnt_q   <= '0;
            clear_q     <= 1'b0;
            print_q     <= 1'b0;
        end else begin
            if (w_push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
            // Illegal ops still consume a sequence number
            if (w_accept)
                seq_q <= seq_q + 1'b1;
            if (w_accept && !w_legal)
                ill_cnt_q <= sat_inc(ill_cnt_q);
            if (w_pop_cmd && (w_head_op <= OP_MAXCPU))
                cpu_cnt_q <= sat_inc(cpu_cnt_q);
            else if (w_pop_cmd)
                snoop_cnt_q <= sat_inc(snoop_cnt_q);
            clear_q <= w_head_ctl && (w_head_op == OP_CLEAR);
            print_q <= w_head_ctl && (w_head_op == OP_PRINT);
        end
    end

    assign clear_pulse_o   = clear_q;
    assign print_pulse_o   = print_q;
    assign fifo_level_o    = level_q;
    assign cpu_count_o     = cpu_cnt_q;
    assign snoop_count_o   = snoop_cnt_q;
    assign illegal_count_o = ill_cnt_q;
endmodule
`default_nettype wire
